fpga_tile_cfg: RTL and testbench
================================

// Module: fpga_tile_cfg
// PURPOSE
//  Parametrised logic tile: N_BLE basic logic elements (K-LUT + optional FF) fed by a local crossbar
//  over tile inputs and registered BLE feedback. Double-buffered config is loaded word-by-word over
//  a valid/ready port and committed atomically. The tile keeps running its old config while a new one loads.
//  Building block for NxN fabric arrays replacing fixed 3x3 parallel-bitstream tops.
// PARAMETERS
//  K      4  LUT inputs per BLE (truth table 2^K bits)
//  N_BLE  4  BLEs in tile
//  N_IN   8  tile input pins
//  CFG_W  8  config word width
//  Derived: SEL_W=clog2(N_IN+N_BLE); PB=2^K+1+K*SEL_W; CFG_BITS=N_BLE*PB; WORDS=ceil(CFG_BITS/CFG_W)
//  Defaults: SEL_W=4, PB=33, CFG_BITS=132, WORDS=17
// PORTS
//  clk         in   1      rising-edge clock
//  reset       in   1      synchronous, active-high
//  tile_in     in   N_IN   fabric inputs
//  ble_out     out  N_BLE  BLE outputs
//  cfg_start   in   1      pulse: begin (re)load, resets word counter
//  cfg_data    in   CFG_W  config word
//  cfg_valid   in   1      cfg_data valid
//  cfg_ready   out  1      word accept (comb: state==LOAD && !cfg_start)
//  cfg_done    out  1      1-cycle pulse on commit
//  configured  out  1      active config valid
// BEHAVIOUR
//  Reset: state IDLE; active cfg, shadow, word count, BLE FFs = 0; ble_out=0, cfg_done=0, configured=0.
//  FSM: IDLE -cfg_start-> LOAD; RUN -cfg_start-> LOAD; LOAD -last word accepted-> COMMIT -> RUN (1 cycle).
//  Accept = cfg_valid && cfg_ready; shadow <= {shadow, cfg_data}; count++. Gaps in cfg_valid allowed.
//  Accept of word WORDS-1 -> next cycle (COMMIT): active <= shadow[CFG_BITS-1:0], all BLE FFs cleared,
//   cfg_done=1, configured=1. Leading pad bits (MSBs of first word) ignored.
//  cfg_start during LOAD: counter -> 0, that cycle's word dropped, shadow contents discarded by overwrite.
//  cfg_start during COMMIT: ignored. cfg_valid outside LOAD: ignored (cfg_ready=0).
//  Layout, BLE j at active[j*PB +: PB]: [2^K-1:0] LUT table; [2^K] ff_en; [2^K+1+i*SEL_W +: SEL_W] sel[i].
//  Crossbar: sel<N_IN -> tile_in[sel]; N_IN<=sel<N_IN+N_BLE -> q[sel-N_IN] (registered FF only,
//   so no combinational loops); sel>=N_IN+N_BLE -> 0.
//  LUT: addr={x[K-1],...,x[0]}; lut_o=LUT[addr]. FF: q<=lut_o every cycle in RUN/LOAD-after-RUN.
//  ble_out[j] = ff_en ? q[j] : lut_o[j], gated to 0 while configured=0.
//  Reload from RUN: configured stays 1, old config and FFs run until COMMIT; switch-over is single-cycle.
//  First load from IDLE: ble_out=0, FFs held 0 until COMMIT.
//  Reset mid-LOAD or mid-RUN: full return to reset state; partial shadow discarded.
// TESTING (defaults)
//  AND4: BLE0 LUT=16'h8000, sel=0,1,2,3, ff_en=0; tile_in=8'h0F -> ble_out[0]=1; 8'h0E -> 0 same cycle.
//  Registered: same with ff_en=1; tile_in 0x00->0x0F -> ble_out[0] rises exactly 1 cycle later.
//  Feedback: BLE1 LUT=16'h5555, sel0=9 (own q), ff_en=1 -> ble_out[1] toggles 0,1,0,... from cycle after commit.
//  Count: 17 words with random cfg_valid gaps -> cfg_done exactly 1 cycle after 17th accept; 16 words -> none.
//  Restart: cfg_start after 10 words -> 17 further words required; reset after 5 words -> configured=0, outputs 0.
//  Reload: AND4 running, load NOT config -> ble_out keeps AND4 until commit cycle, then NOT; configured never drops.

Source files
------------

// File: rtl/fpga_tile_cfg.sv
// Logic tile: N_BLE K-LUT BLEs behind a local crossbar, with a
// double-buffered configuration loaded over a valid/ready word port.
module fpga_tile_cfg #(
    parameter int K     = 4,
    parameter int N_BLE = 4,
    parameter int N_IN  = 8,
    parameter int CFG_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [N_IN-1:0]  tile_in,
    output logic [N_BLE-1:0] ble_out,
    input  logic             cfg_start,
    input  logic [CFG_W-1:0] cfg_data,
    input  logic             cfg_valid,
    output logic             cfg_ready,
    output logic             cfg_done,
    output logic             configured
);

    localparam int LUT_N    = 1 << K;
    localparam int SEL_W    = $clog2(N_IN + N_BLE);
    localparam int SRC_N    = 1 << SEL_W;
    localparam int PB       = LUT_N + 1 + K * SEL_W;
    localparam int CFG_BITS = N_BLE * PB;
    localparam int WORDS    = (CFG_BITS + CFG_W - 1) / CFG_W;
    localparam int SH_W     = WORDS * CFG_W;
    localparam int CNT_W    = $clog2(WORDS + 1);

    localparam logic [CNT_W-1:0] LAST = CNT_W'(WORDS - 1);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_LOAD   = 2'd1;
    localparam logic [1:0] S_COMMIT = 2'd2;
    localparam logic [1:0] S_RUN    = 2'd3;

    logic [1:0]          state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [SH_W-1:0]     shadow_q, shadow_d;
    logic [CFG_BITS-1:0] active_q;
    logic [N_BLE-1:0]    ble_q;
    logic                done_q;
    logic                cfgd_q;
    logic                commit;
    logic                accept;
    logic [N_BLE-1:0]    lut_o;
    logic [SRC_N-1:0]    src;

    assign cfg_ready  = (state_q == S_LOAD) && !cfg_start;
    assign accept     = cfg_valid && cfg_ready;
    assign cfg_done   = done_q;
    assign configured = cfgd_q;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        shadow_d = shadow_q;
        commit   = 1'b0;
        case (state_q)
            S_IDLE, S_RUN: begin
                if (cfg_start) begin
                    state_d = S_LOAD;
                    cnt_d   = '0;
                end
            end
            S_LOAD: begin
                if (cfg_start) begin
                    cnt_d = '0;
                end else if (accept) begin
                    shadow_d = {shadow_q[SH_W-CFG_W-1:0], cfg_data};
                    if (cnt_q == LAST) begin
                        state_d = S_COMMIT;
                        cnt_d   = '0;
                        commit  = 1'b1;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            S_COMMIT: state_d = S_RUN;
            default:  state_d = S_IDLE;
        endcase
    end

    // Commit happens on the edge that accepts the last word, so the
    // new config is already live during the cfg_done cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            shadow_q <= '0;
            active_q <= '0;
            ble_q    <= '0;
            done_q   <= 1'b0;
            cfgd_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            shadow_q <= shadow_d;
            done_q   <= commit;
            if (commit) begin
                active_q <= shadow_d[CFG_BITS-1:0];
                cfgd_q   <= 1'b1;
                ble_q    <= '0;
            end else if (cfgd_q) begin
                ble_q <= lut_o;
            end
        end
    end

    always_comb begin
        src                = '0;
        src[N_IN-1:0]      = tile_in;
        src[N_IN +: N_BLE] = ble_q;
    end

    for (genvar j = 0; j < N_BLE; j++) begin : g_ble
        logic [LUT_N-1:0] tbl;
        logic             ff_en;
        logic [K-1:0]     x;

        assign tbl   = active_q[j*PB +: LUT_N];
        assign ff_en = active_q[j*PB + LUT_N];

        for (genvar i = 0; i < K; i++) begin : g_sel
            logic [SEL_W-1:0] sel;
            assign sel  = active_q[j*PB + LUT_N + 1 + i*SEL_W +: SEL_W];
            assign x[i] = src[sel];
        end

        assign lut_o[j]   = tbl[x];
        assign ble_out[j] = cfgd_q & (ff_en ? ble_q[j] : lut_o[j]);
    end

endmodule

// File: tb/tb_fpga_tile_cfg.sv
// Scoreboard bench for fpga_tile_cfg: a per-cycle reference model
// pushes expected outputs; a negedge monitor pops and compares.
module tb_fpga_tile_cfg;

    localparam int NW = 17;

    typedef struct packed {
        bit [3:0][15:0]     lut;
        bit [3:0]           ff;
        bit [3:0][3:0][3:0] sel;
    } cfg_t;

    typedef struct packed {
        bit [3:0] ble;
        bit       done;
        bit       cfgd;
        bit       rdy;
    } exp_t;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [7:0] tile_in = '0;
    logic [3:0] ble_out;
    logic       cfg_start = 1'b0;
    logic [7:0] cfg_data = '0;
    logic       cfg_valid = 1'b0;
    logic       cfg_ready;
    logic       cfg_done;
    logic       configured;

    always #5 clk = ~clk;

    fpga_tile_cfg dut (
        .clk       (clk),
        .reset     (reset),
        .tile_in   (tile_in),
        .ble_out   (ble_out),
        .cfg_start (cfg_start),
        .cfg_data  (cfg_data),
        .cfg_valid (cfg_valid),
        .cfg_ready (cfg_ready),
        .cfg_done  (cfg_done),
        .configured(configured)
    );

    int   errors = 0;
    int   checks = 0;
    exp_t exp_q[$];

    cfg_t     m_cfg = '0;
    bit       m_cfgd = 0;
    bit       m_load = 0;
    bit       m_commit = 0;
    bit [3:0] m_q = '0;
    bit [7:0] m_words[$];
    int       m_commits = 0;
    int       seen_done = 0;

    function automatic bit [3:0] lut_vec(cfg_t c, bit [7:0] tin,
                                         bit [3:0] q);
        bit [3:0] r;
        for (int j = 0; j < 4; j++) begin
            bit [3:0] a;
            for (int i = 0; i < 4; i++) begin
                int s;
                s = int'(c.sel[j][i]);
                if (s < 8)       a[i] = tin[s];
                else if (s < 12) a[i] = q[s-8];
                else             a[i] = 1'b0;
            end
            r[j] = c.lut[j][a];
        end
        return r;
    endfunction

    function automatic bit [135:0] pack_cfg(cfg_t c);
        bit [135:0] b;
        b = '0;
        for (int j = 0; j < 4; j++) begin
            b[j*33 +: 16] = c.lut[j];
            b[j*33 + 16]  = c.ff[j];
            for (int i = 0; i < 4; i++)
                b[j*33 + 17 + i*4 +: 4] = c.sel[j][i];
        end
        b[135:132] = 4'($urandom);
        return b;
    endfunction

    function automatic cfg_t unpack_cfg(bit [135:0] b);
        cfg_t c;
        for (int j = 0; j < 4; j++) begin
            c.lut[j] = b[j*33 +: 16];
            c.ff[j]  = b[j*33 + 16];
            for (int i = 0; i < 4; i++)
                c.sel[j][i] = b[j*33 + 17 + i*4 +: 4];
        end
        return c;
    endfunction

    function automatic cfg_t rand_cfg();
        cfg_t c;
        for (int j = 0; j < 4; j++) begin
            c.lut[j] = 16'($urandom);
            c.ff[j]  = 1'($urandom);
            for (int i = 0; i < 4; i++)
                c.sel[j][i] = 4'($urandom);
        end
        return c;
    endfunction

    task automatic step(bit rst, bit st, bit v, bit [7:0] d,
                        bit [7:0] tin);
        exp_t       e;
        bit [3:0]   lv;
        bit         rdy;
        bit         fresh;
        bit [135:0] b;
        reset     = rst;
        cfg_start = st;
        cfg_valid = v;
        cfg_data  = d;
        tile_in   = tin;
        lv  = lut_vec(m_cfg, tin, m_q);
        rdy = m_load && !st;
        e.rdy  = rdy;
        e.done = m_commit;
        e.cfgd = m_cfgd;
        for (int j = 0; j < 4; j++)
            e.ble[j] = m_cfgd && (m_cfg.ff[j] ? m_q[j] : lv[j]);
        exp_q.push_back(e);
        @(posedge clk);
        fresh = 0;
        if (rst) begin
            m_cfg    = '0;
            m_cfgd   = 0;
            m_load   = 0;
            m_commit = 0;
            m_q      = '0;
            m_words.delete();
        end else begin
            if (m_commit) begin
                m_commit = 0;
            end else if (st) begin
                m_load = 1;
                m_words.delete();
            end else if (v && rdy) begin
                m_words.push_back(d);
                if (m_words.size() == NW) begin
                    b = '0;
                    foreach (m_words[w]) b = {b[127:0], m_words[w]};
                    m_cfg    = unpack_cfg(b);
                    m_cfgd   = 1;
                    m_load   = 0;
                    m_commit = 1;
                    fresh    = 1;
                    m_commits++;
                end
            end
            if (fresh)       m_q = '0;
            else if (m_cfgd) m_q = lv;
        end
        #1;
    endtask

    task automatic idle(int n, bit vld);
        for (int k = 0; k < n; k++)
            step(0, 0, vld & 1'($urandom), 8'($urandom), 8'($urandom));
    endtask

    task automatic run_tin(bit [7:0] tin, int n);
        for (int k = 0; k < n; k++)
            step(0, 0, 0, 8'($urandom), tin);
    endtask

    task automatic load(cfg_t c, int nwords);
        bit [135:0] b;
        b = pack_cfg(c);
        step(0, 1, 1, 8'($urandom), 8'($urandom));
        for (int w = 0; w < nwords; w++) begin
            while ($urandom_range(0, 2) == 0)
                step(0, 0, 0, 8'($urandom), 8'($urandom));
            step(0, 0, 1, b[(NW-1-w)*8 +: 8], 8'($urandom));
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (cfg_done === 1'b1) seen_done++;
        if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            checks += 4;
            if (ble_out !== e.ble) begin
                errors++;
                $display("FAIL ble_out t=%0t got=%b want=%b",
                         $time, ble_out, e.ble);
            end
            if (cfg_done !== e.done) begin
                errors++;
                $display("FAIL cfg_done t=%0t got=%b want=%b",
                         $time, cfg_done, e.done);
            end
            if (configured !== e.cfgd) begin
                errors++;
                $display("FAIL configured t=%0t got=%b want=%b",
                         $time, configured, e.cfgd);
            end
            if (cfg_ready !== e.rdy) begin
                errors++;
                $display("FAIL cfg_ready t=%0t got=%b want=%b",
                         $time, cfg_ready, e.rdy);
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog expired at t=%0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        cfg_t c_and, c_reg, c_fb, c_not, c_r;
        @(posedge clk);
        #1;
        for (int k = 0; k < 3; k++)
            step(1, 0, 1'($urandom), 8'($urandom), 8'($urandom));
        idle(4, 1);

        c_and = rand_cfg();
        c_and.lut[0] = 16'h8000;
        c_and.ff[0]  = 1'b0;
        for (int i = 0; i < 4; i++) c_and.sel[0][i] = 4'(i);
        load(c_and, NW);
        run_tin(8'h0F, 2);
        run_tin(8'h0E, 2);
        idle(10, 1);

        c_reg = c_and;
        c_reg.ff[0] = 1'b1;
        load(c_reg, NW);
        run_tin(8'h00, 3);
        run_tin(8'h0F, 3);
        run_tin(8'h0E, 2);

        c_fb = rand_cfg();
        c_fb.lut[1] = 16'h5555;
        c_fb.ff[1]  = 1'b1;
        c_fb.sel[1][0] = 4'd9;
        load(c_fb, NW);
        idle(8, 0);

        c_r = rand_cfg();
        load(c_r, 16);
        idle(6, 0);
        load(c_r, 10);
        load(c_r, NW);
        idle(5, 1);

        load(rand_cfg(), 5);
        step(1, 0, 1, 8'($urandom), 8'($urandom));
        idle(5, 1);

        load(c_and, NW);
        idle(6, 1);
        c_not = c_and;
        c_not.lut[0] = 16'h5555;
        for (int i = 0; i < 4; i++) c_not.sel[0][i] = 4'd0;
        load(c_not, NW);
        idle(6, 1);

        for (int r = 0; r < 8; r++) begin
            load(rand_cfg(), NW);
            idle(int'($urandom_range(3, 12)), 1);
        end

        @(negedge clk);
        #1;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain got=%0d want=0", exp_q.size());
        end
        checks++;
        if (seen_done != m_commits) begin
            errors++;
            $display("FAIL done_count got=%0d want=%0d",
                     seen_done, m_commits);
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
